// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply unit: default width, HI/LO select
// encoding and the multiplier state enum.
package mips_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mult_state_e;

endpackage

// File: rtl/mult_shift_add_core.sv
// Radix-2 shift-add magnitude multiplier: one iteration per step, WIDTH steps
// after a load. The accumulator carries one spare bit above the product.
module mult_shift_add_core
  import mips_pkg::*;
#(
  parameter int WIDTH = mips_pkg::WIDTH,
  parameter int CNT_W = mips_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic [2*WIDTH-1:0] prod_o,
  output logic               last_o
);

  logic [2*WIDTH:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] addend_d;
  logic [WIDTH:0]   sum_d;
  logic [2*WIDTH:0] acc_d;

  always_comb begin
    addend_d = mplier_q[0] ? mcand_q : '0;
    sum_d    = acc_q[2*WIDTH:WIDTH] + {1'b0, addend_d};
    // The add's carry lands in the top of the shifted upper half.
    acc_d    = {1'b0, sum_d, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      acc_q    <= '0;
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      cnt_q    <= CNT_W'(WIDTH - 1);
    end else if (step_i) begin
      acc_q    <= acc_d;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - 1'b1;
    end
  end

  assign prod_o = acc_q[2*WIDTH-1:0];
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/hilo_mult_unit.sv
// Iterative 32x32 mult/multu with HI/LO register pair; stalls the pipeline when
// a multiply or HI/LO read is issued while a multiply is still in flight.
module hilo_mult_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = mips_pkg::WIDTH,
  parameter int CNT_W = mips_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hl_sel,
  input  logic             rd_req,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  mult_state_e      state_q;
  logic             busy_q;
  logic             done_q;
  logic             neg_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH-1:0]   mag_a_d;
  logic [WIDTH-1:0]   mag_b_d;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] res_d;
  logic               load;
  logic               step;
  logic               last;

  // Negating -2^(WIDTH-1) wraps back to 2^(WIDTH-1), which is the right magnitude.
  always_comb begin
    mag_a_d = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b_d = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    res_d   = neg_q ? -prod : prod;
  end

  assign load = (state_q == IDLE) && start;
  assign step = (state_q == RUN);

  mult_shift_add_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load),
    .step_i   (step),
    .mcand_i  (mag_a_d),
    .mplier_i (mag_b_d),
    .prod_o   (prod),
    .last_o   (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            neg_q   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (last) state_q <= FIX;
        end
        FIX: begin
          {hi_q, lo_q} <= res_d;
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hilo_out = (hl_sel == SEL_HI) ? hi_q : lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign stall    = busy_q & (start | rd_req);

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Scenario-per-task bench for hilo_mult_unit with a 64-bit arithmetic reference.
module tb_hilo_mult_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         hl_sel;
  logic         rd_req;
  logic [W-1:0] hilo_out;
  logic         busy;
  logic         done;
  logic         stall;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hilo_mult_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .hl_sel    (hl_sel),
    .rd_req    (rd_req),
    .hilo_out  (hilo_out),
    .busy      (busy),
    .done      (done),
    .stall     (stall)
  );

  // Reference: sign- or zero-extend to 64 bits and multiply; the low 64 bits are {HI,LO}.
  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input bit s);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = s ? {{32{a[W-1]}}, a} : {32'b0, a};
    eb = s ? {{32{b[W-1]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Called just after a falling edge; returns just after the issuing rising edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    start = 1'b1; is_signed = s; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns on the falling edge where done is seen (or after the cycle budget).
  task automatic wait_done(output int busy_cycles, output bit seen);
    busy_cycles = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    hl_sel = 1'b0; rd_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (hilo_out !== 32'h0) $display("FAIL reset_lo: got %h want 0", hilo_out); else n_pass++;
    hl_sel = 1'b1; #1;
    n_total++; if (hilo_out !== 32'h0) $display("FAIL reset_hi: got %h want 0", hilo_out); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6];
    logic [W-1:0] tb_ [6];
    bit           ts [6];
    logic [W-1:0] thi [6];
    logic [W-1:0] tlo [6];
    int  cyc;
    bit  seen;
    ta[0] = 32'd7;        tb_[0] = 32'd6;        ts[0] = 0; thi[0] = 32'h0;        tlo[0] = 32'h2A;
    ta[1] = 32'hFFFFFFFF; tb_[1] = 32'hFFFFFFFF; ts[1] = 0; thi[1] = 32'hFFFFFFFE; tlo[1] = 32'h1;
    ta[2] = 32'hFFFFFFFD; tb_[2] = 32'd5;        ts[2] = 1; thi[2] = 32'hFFFFFFFF; tlo[2] = 32'hFFFFFFF1;
    ta[3] = 32'h80000000; tb_[3] = 32'h80000000; ts[3] = 1; thi[3] = 32'h40000000; tlo[3] = 32'h0;
    ta[4] = 32'hFFFFFFFF; tb_[4] = 32'hFFFFFFFF; ts[4] = 1; thi[4] = 32'h0;        tlo[4] = 32'h1;
    ta[5] = 32'h80000000; tb_[5] = 32'd1;        ts[5] = 1; thi[5] = 32'hFFFFFFFF; tlo[5] = 32'h80000000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      issue(ta[k], tb_[k], ts[k]);
      wait_done(cyc, seen);
      n_total++; if (!seen) $display("FAIL dir%0d_done: no done pulse", k); else n_pass++;
      n_total++; if (cyc != 33) $display("FAIL dir%0d_busy_cycles: got %0d want 33", k, cyc); else n_pass++;
      hl_sel = 1'b1; #1;
      n_total++; if (hilo_out !== thi[k]) $display("FAIL dir%0d_hi: got %h want %h", k, hilo_out, thi[k]); else n_pass++;
      hl_sel = 1'b0; #1;
      n_total++; if (hilo_out !== tlo[k]) $display("FAIL dir%0d_lo: got %h want %h", k, hilo_out, tlo[k]); else n_pass++;
      @(negedge clk);
      n_total++; if (done !== 1'b0) $display("FAIL dir%0d_done_pulse: got %b want 0", k, done); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           s;
    logic [63:0]  exp;
    int  cyc;
    bit  seen;
    for (int k = 0; k < 10; k++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      if (k == 0) a = 32'h0;
      exp = ref_mul(a, b, s);
      @(negedge clk);
      issue(a, b, s);
      wait_done(cyc, seen);
      n_total++; if (!seen || cyc != 33) $display("FAIL rnd%0d_timing: cycles %0d seen %b want 33/1", k, cyc, seen); else n_pass++;
      hl_sel = 1'b1; #1;
      n_total++; if (hilo_out !== exp[63:32]) $display("FAIL rnd%0d_hi: got %h want %h", k, hilo_out, exp[63:32]); else n_pass++;
      hl_sel = 1'b0; #1;
      n_total++; if (hilo_out !== exp[31:0]) $display("FAIL rnd%0d_lo: got %h want %h", k, hilo_out, exp[31:0]); else n_pass++;
    end
  endtask

  task automatic test_stall();
    int cyc;
    bit seen;
    @(negedge clk);
    issue(32'd3, 32'd4, 1'b0);
    wait_done(cyc, seen);
    @(negedge clk);
    issue(32'd7, 32'd6, 1'b0);
    repeat (5) @(negedge clk);
    start = 1'b1; op_a = 32'd9; op_b = 32'd9; #1;
    n_total++; if (stall !== 1'b1) $display("FAIL stall_start: got %b want 1", stall); else n_pass++;
    @(negedge clk);
    start = 1'b0; rd_req = 1'b1; hl_sel = 1'b0; #1;
    n_total++; if (stall !== 1'b1) $display("FAIL stall_read: got %b want 1", stall); else n_pass++;
    n_total++; if (hilo_out !== 32'd12) $display("FAIL stall_old_lo: got %h want %h", hilo_out, 32'd12); else n_pass++;
    @(negedge clk);
    rd_req = 1'b0;
    wait_done(cyc, seen);
    n_total++; if (!seen) $display("FAIL stall_done: no done pulse"); else n_pass++;
    n_total++; if (hilo_out !== 32'd42) $display("FAIL stall_result: got %h want %h", hilo_out, 32'd42); else n_pass++;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL stall_no_restart: busy %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen;
    logic [63:0] exp;
    @(negedge clk);
    issue(32'd7, 32'd6, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", done); else n_pass++;
    hl_sel = 1'b0; #1;
    n_total++; if (hilo_out !== 32'h0) $display("FAIL rstmid_lo: got %h want 0", hilo_out); else n_pass++;
    hl_sel = 1'b1; #1;
    n_total++; if (hilo_out !== 32'h0) $display("FAIL rstmid_hi: got %h want 0", hilo_out); else n_pass++;
    exp = ref_mul(32'd12345, 32'hFFFFFD52, 1'b1);
    @(negedge clk);
    issue(32'd12345, 32'hFFFFFD52, 1'b1);
    wait_done(cyc, seen);
    n_total++; if (!seen || cyc != 33) $display("FAIL rstmid_timing: cycles %0d seen %b want 33/1", cyc, seen); else n_pass++;
    hl_sel = 1'b1; #1;
    n_total++; if (hilo_out !== exp[63:32]) $display("FAIL rstmid_hi_after: got %h want %h", hilo_out, exp[63:32]); else n_pass++;
    hl_sel = 1'b0; #1;
    n_total++; if (hilo_out !== exp[31:0]) $display("FAIL rstmid_lo_after: got %h want %h", hilo_out, exp[31:0]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit seen;
    logic [63:0] e1;
    logic [63:0] e2;
    e1 = ref_mul(32'd100000, 32'd300000, 1'b0);
    e2 = ref_mul(32'hFFFF0000, 32'd65536, 1'b1);
    @(negedge clk);
    issue(32'd100000, 32'd300000, 1'b0);
    wait_done(cyc, seen);
    // done cycle: new result readable without stall, and a new start is taken
    start = 1'b1; is_signed = 1'b1; op_a = 32'hFFFF0000; op_b = 32'd65536;
    rd_req = 1'b1; hl_sel = 1'b0; #1;
    n_total++; if (stall !== 1'b0) $display("FAIL b2b_stall: got %b want 0", stall); else n_pass++;
    n_total++; if (hilo_out !== e1[31:0]) $display("FAIL b2b_read_lo: got %h want %h", hilo_out, e1[31:0]); else n_pass++;
    hl_sel = 1'b1; #1;
    n_total++; if (hilo_out !== e1[63:32]) $display("FAIL b2b_read_hi: got %h want %h", hilo_out, e1[63:32]); else n_pass++;
    @(posedge clk); #1;
    start = 1'b0; rd_req = 1'b0;
    wait_done(cyc, seen);
    n_total++; if (!seen || cyc != 33) $display("FAIL b2b_timing: cycles %0d seen %b want 33/1", cyc, seen); else n_pass++;
    hl_sel = 1'b1; #1;
    n_total++; if (hilo_out !== e2[63:32]) $display("FAIL b2b_hi2: got %h want %h", hilo_out, e2[63:32]); else n_pass++;
    hl_sel = 1'b0; #1;
    n_total++; if (hilo_out !== e2[31:0]) $display("FAIL b2b_lo2: got %h want %h", hilo_out, e2[31:0]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
